// File: rtl/prefetch_queue_if.sv
// Handshake bundle between fetch unit, decoder and prefetch_queue.
// The slave modport is the queue's view; the master modport is the fetch/decode side.
// Optional signal o_fetch_req exists only when PFQ_LOWMARK_EN is defined.
interface prefetch_queue_if #(
    parameter int AW   = 4,
    parameter int PEEK = 3
);
    logic                 i_flush;
    logic                 i_push_valid;
    logic [7:0]           i_push_data;
    logic                 o_push_ready;
    logic [1:0]           i_pop_len;
    logic [8*PEEK-1:0]    o_head_bytes;
    logic [AW:0]          o_head_count;
    logic                 o_pop_err;
`ifdef PFQ_LOWMARK_EN
    logic                 o_fetch_req;
`endif

    modport master (
        output i_flush,
        output i_push_valid,
        output i_push_data,
        output i_pop_len,
        input  o_push_ready,
        input  o_head_bytes,
        input  o_head_count,
        input  o_pop_err
`ifdef PFQ_LOWMARK_EN
        ,
        input  o_fetch_req
`endif
    );

    modport slave (
        input  i_flush,
        input  i_push_valid,
        input  i_push_data,
        input  i_pop_len,
        output o_push_ready,
        output o_head_bytes,
        output o_head_count,
        output o_pop_err
`ifdef PFQ_LOWMARK_EN
        ,
        output o_fetch_req
`endif
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction-byte prefetch queue: one byte pushed per cycle by fetch, the head
// PEEK bytes exposed in parallel to the decoder, 0..PEEK bytes popped per cycle.
// Flush discards everything. Optional macro PFQ_LOWMARK_EN adds the registered
// o_fetch_req low-water-mark output.
module prefetch_queue #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int PEEK    = 3,
    parameter int LOWMARK = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    prefetch_queue_if.slave bus
);
    logic [7:0]        r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW:0]       r_count;
    logic              r_pop_err;

    logic              w_push_ready;
    logic              w_push;
    logic              w_pop_legal;
    logic [AW:0]       w_pop_len;
    logic [AW:0]       w_pop_amt;
    logic [AW:0]       w_count_next;
    logic [AW-1:0]     w_idx [PEEK];
    logic [8*PEEK-1:0] w_head;

    // Legality is judged on the count before this cycle's push; a pop never frees room for a same-cycle push.
    assign w_push_ready = (r_count != (AW+1)'(DEPTH));
    assign w_push       = bus.i_push_valid && w_push_ready && !bus.i_flush && !i_rst;
    assign w_pop_len    = (AW+1)'(bus.i_pop_len);
    assign w_pop_legal  = (w_pop_len <= r_count) && (w_pop_len <= (AW+1)'(PEEK));
    assign w_pop_amt    = w_pop_legal ? w_pop_len : '0;

    // Next occupancy: flush empties, otherwise add the accepted push and subtract the legal pop.
    always_comb begin
        w_count_next = r_count + (AW+1)'(w_push) - w_pop_amt;
        if (bus.i_flush) begin
            w_count_next = '0;
        end
    end

    // Pointers, count and the one-cycle pop error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_pop_err <= 1'b0;
        end else if (bus.i_flush) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_pop_err <= 1'b0;
        end else begin
            r_rd_ptr  <= r_rd_ptr + w_pop_amt[AW-1:0];
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count   <= w_count_next;
            r_pop_err <= !w_pop_legal;
        end
    end

    // Byte storage; deliberately not reset, pointers alone define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.i_push_data;
        end
    end

    // Head window: wrapping read from rd_ptr, slots past the stored count read as zero.
    always_comb begin
        w_head = '0;
        for (int i = 0; i < PEEK; i++) begin
            w_idx[i] = r_rd_ptr + AW'(i);
            if ((AW+1)'(i) < r_count) begin
                w_head[8*i +: 8] = r_mem[w_idx[i]];
            end
        end
    end

    assign bus.o_push_ready = w_push_ready;
    assign bus.o_head_bytes = w_head;
    assign bus.o_head_count = r_count;
    assign bus.o_pop_err    = r_pop_err;

`ifdef PFQ_LOWMARK_EN
    logic r_fetch_req;

    // Request more bytes when next cycle's occupancy is at or below the low mark.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush) begin
            r_fetch_req <= 1'b1;
        end else begin
            r_fetch_req <= (w_count_next <= (AW+1)'(LOWMARK));
        end
    end

    assign bus.o_fetch_req = r_fetch_req;
`endif
endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: a vector table for the short
// directed cases plus a byte-queue scoreboard checked every cycle.
module tb_prefetch_queue;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PEEK  = 3;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    prefetch_queue_if #(.AW(AW), .PEEK(PEEK)) bus ();

    prefetch_queue #(.DEPTH(DEPTH), .AW(AW), .PEEK(PEEK), .LOWMARK(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    typedef struct {
        logic        fl;
        logic        pv;
        logic [7:0]  pd;
        logic [1:0]  pl;
        int          exp_cnt;
        logic        exp_rdy;
        logic [23:0] exp_head;
        logic        exp_err;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] mq [$];
    logic       m_err;
    logic       m_freq;
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_head();
        logic [23:0] h;
        h = '0;
        for (int i = 0; i < PEEK; i++) begin
            if (i < mq.size()) h[8*i +: 8] = mq[i];
        end
        return h;
    endfunction

    task automatic check_state();
        chk("count", 32'(bus.o_head_count), 32'(mq.size()));
        chk("push_ready", 32'(bus.o_push_ready), 32'(mq.size() != DEPTH));
        chk("head_bytes", 32'(bus.o_head_bytes), 32'(model_head()));
        chk("pop_err", 32'(bus.o_pop_err), 32'(m_err));
`ifdef PFQ_LOWMARK_EN
        chk("fetch_req", 32'(bus.o_fetch_req), 32'(m_freq));
`endif
    endtask

    // One clock: popped bytes are compared against the scoreboard before the edge,
    // the full state after it.
    task automatic cycle(input logic fl, input logic pv, input logic [7:0] pd, input logic [1:0] pl);
        int  sz;
        logic legal, acc;
        sz    = mq.size();
        legal = (int'(pl) <= sz);
        acc   = pv && (sz != DEPTH) && !fl;
        if (!fl && legal) begin
            for (int i = 0; i < int'(pl); i++) begin
                chk("pop_byte", 32'(bus.o_head_bytes[8*i +: 8]), 32'(mq[i]));
            end
        end
        bus.i_flush      = fl;
        bus.i_push_valid = pv;
        bus.i_push_data  = pd;
        bus.i_pop_len    = pl;
        @(posedge i_clk);
        #1;
        if (fl) begin
            mq.delete();
            m_err  = 1'b0;
            m_freq = 1'b1;
        end else begin
            if (legal) begin
                for (int i = 0; i < int'(pl); i++) void'(mq.pop_front());
            end
            if (acc) mq.push_back(pd);
            m_err  = !legal;
            m_freq = (mq.size() <= 4);
        end
        check_state();
    endtask

    task automatic do_reset();
        i_rst            = 1'b1;
        bus.i_flush      = 1'b1;
        bus.i_push_valid = 1'b1;
        bus.i_push_data  = 8'hCC;
        bus.i_pop_len    = 2'd1;
        @(posedge i_clk);
        #1;
        i_rst            = 1'b0;
        bus.i_flush      = 1'b0;
        bus.i_push_valid = 1'b0;
        bus.i_pop_len    = 2'd0;
        mq.delete();
        m_err  = 1'b0;
        m_freq = 1'b1;
        chk("rst_count", 32'(bus.o_head_count), 32'd0);
        chk("rst_ready", 32'(bus.o_push_ready), 32'd1);
        chk("rst_err", 32'(bus.o_pop_err), 32'd0);
        chk("rst_head", 32'(bus.o_head_bytes), 32'd0);
`ifdef PFQ_LOWMARK_EN
        chk("rst_fetch_req", 32'(bus.o_fetch_req), 32'd1);
`endif
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'hA9, 2'd0, 1, 1'b1, 24'h0000A9, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'h05, 2'd0, 2, 1'b1, 24'h0005A9, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 2'd3, 2, 1'b1, 24'h0005A9, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 2'd0, 2, 1'b1, 24'h0005A9, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 2'd2, 0, 1'b1, 24'h000000, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h11, 2'd1, 1, 1'b1, 24'h000011, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 2'd1, 0, 1'b1, 24'h000000, 1'b0};

        bus.i_flush      = 1'b0;
        bus.i_push_valid = 1'b0;
        bus.i_push_data  = 8'h00;
        bus.i_pop_len    = 2'd0;
        m_err  = 1'b0;
        m_freq = 1'b1;
        @(posedge i_clk);
        do_reset();

        for (int r = 0; r < 7; r++) begin
            cycle(tbl[r].fl, tbl[r].pv, tbl[r].pd, tbl[r].pl);
            chk("tbl_count", 32'(bus.o_head_count), 32'(tbl[r].exp_cnt));
            chk("tbl_ready", 32'(bus.o_push_ready), 32'(tbl[r].exp_rdy));
            chk("tbl_head", 32'(bus.o_head_bytes), 32'(tbl[r].exp_head));
            chk("tbl_err", 32'(bus.o_pop_err), 32'(tbl[r].exp_err));
        end

        // Fill to full with pointers starting mid-buffer, then push into a full queue.
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 8'(k), 2'd0);
        chk("full_count", 32'(bus.o_head_count), 32'd16);
        chk("full_ready", 32'(bus.o_push_ready), 32'd0);
        cycle(1'b0, 1'b1, 8'hEE, 2'd0);
        chk("full_ignored_count", 32'(bus.o_head_count), 32'd16);
        chk("full_head0", 32'(bus.o_head_bytes[7:0]), 32'h00);

        // Pop from full with a same-cycle push: the push is refused since ready was low.
        cycle(1'b0, 1'b1, 8'h10, 2'd3);
        chk("full_pop_count", 32'(bus.o_head_count), 32'd13);
        cycle(1'b0, 1'b1, 8'h10, 2'd0);
        chk("refill_count", 32'(bus.o_head_count), 32'd14);

        // Sustained push/pop to run both pointers around the wrap several times.
        for (int k = 0; k < 48; k++) cycle(1'b0, 1'b1, 8'(8'h20 + k), 2'(k % 3));
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
        end

        // Flush with competing push and pop.
        cycle(1'b1, 1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 8'(8'h40 + k), 2'd0);
        chk("pre_flush_count", 32'(bus.o_head_count), 32'd9);
        cycle(1'b1, 1'b1, 8'h77, 2'd2);
        chk("flush_count", 32'(bus.o_head_count), 32'd0);
        chk("flush_ready", 32'(bus.o_push_ready), 32'd1);
        chk("flush_head", 32'(bus.o_head_bytes), 32'd0);
        cycle(1'b0, 1'b1, 8'h5A, 2'd0);
        chk("post_flush_head0", 32'(bus.o_head_bytes[7:0]), 32'h5A);

`ifdef PFQ_LOWMARK_EN
        cycle(1'b1, 1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b1, 8'(8'h60 + k), 2'd0);
            chk("lm_fill_fetch_req", 32'(bus.o_fetch_req), 32'(k < 4));
        end
        cycle(1'b0, 1'b0, 8'h00, 2'd2);
        chk("lm_pop_fetch_req", 32'(bus.o_fetch_req), 32'd1);
        cycle(1'b0, 1'b1, 8'h70, 2'd0);
        chk("lm_push_fetch_req", 32'(bus.o_fetch_req), 32'd0);
`endif

        // Reset in the middle of traffic overrides flush, push and pop.
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 8'(8'h90 + k), 2'd0);
        do_reset();
        cycle(1'b0, 1'b1, 8'hB1, 2'd0);
        chk("post_reset_head0", 32'(bus.o_head_bytes[7:0]), 32'hB1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
